mem_tx_sequencer: RTL and testbench

- Controller that turns a one-cycle start pulse from the positive-edge detector on a debounced button into a complete memory-to-UART transfer.
- Reads MSG_LEN consecutive bytes from the synchronous-read message memory, starting at START_ADDR.
- Hands each byte to the UART transmitter through a start/ready handshake.
- Sits between the edge detector, the memory and the UART TX; it is the only block that drives the memory read address and the TX start strobe.

---
 rtl/mem_tx_sequencer.sv | 84 ++++++++
 tb/tb_mem_tx_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tx_sequencer.sv
// mem_tx_sequencer: walks MSG_LEN bytes of a synchronous-read message memory
// starting at START_ADDR and hands each one to a UART transmitter through a
// start/ready handshake. Started by a one-cycle pulse, cancellable by abort.
module mem_tx_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int MSG_LEN    = 16,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ped,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(MSG_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(MSG_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {
    IDLE, READ, LOAD, WAIT_RDY, SEND, WAIT_ACK, DONE
  } state_t;

  state_t           state, next;
  logic [CNT_W-1:0] count;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (ped && !abort) next = READ;
      READ:     next = LOAD;
      LOAD:     next = WAIT_RDY;
      WAIT_RDY: if (tx_ready) next = SEND;
      SEND:     next = WAIT_ACK;
      WAIT_ACK: if (!tx_ready) next = (count == LAST) ? DONE : READ;
      DONE:     next = IDLE;
      default:  next = IDLE;
    endcase
    if (abort && state != IDLE) next = IDLE;
  end

  // Registered outputs are derived from the upcoming state so each strobe
  // lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= BASE;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      tx_start <= (next == SEND);
      done     <= (next == DONE);
      busy     <= (next != IDLE);
      if (state == IDLE && next == READ) begin
        mem_addr <= BASE;
        count    <= '0;
      end
      // mem_data reflects the address presented during READ.
      if (state == LOAD && next == WAIT_RDY) tx_data <= mem_data;
      // Address wraps naturally at 2^ADDR_W.
      if (state == WAIT_ACK && next == READ) begin
        count    <= count + CNT_W'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (abort && state != IDLE) mem_addr <= BASE;
    end
  end

endmodule

// File: tb/tb_mem_tx_sequencer.sv
// Scoreboard bench for mem_tx_sequencer (MSG_LEN=4, START_ADDR=0xFE so the
// address wrap is exercised on every transfer).
module tb_mem_tx_sequencer;

  localparam int ADDR_W = 8;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ped = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  exp_t       sb [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         tx_cnt = 0;
  int         done_cnt = 0;
  int         tx_busy = 1;
  int         busy_left = 0;
  logic       stall = 1'b0;

  // Hand-computed message: addresses FE,FF,00,01 hold 41..44.
  logic [7:0] msg_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] msg_data [4] = '{8'h41, 8'h42, 8'h43, 8'h44};

  mem_tx_sequencer #(.ADDR_W(ADDR_W), .MSG_LEN(4), .START_ADDR(8'hFE)) dut (
    .clk(clk), .reset(reset), .ped(ped), .abort(abort),
    .mem_addr(mem_addr), .mem_data(mem_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Transmitter model: goes busy for tx_busy cycles after each strobe.
  always @(posedge clk) begin
    if (tx_start)           busy_left <= tx_busy;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tx_ready = (busy_left == 0) && !stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      tx_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tx_start: got data %0h addr %0h expected none", tx_data, mem_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_data", {24'h0, tx_data}, {24'h0, e.data});
        chk("tx_addr", {24'h0, mem_addr}, {24'h0, e.addr});
      end
    end
    if (!reset && done) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_msg(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{msg_addr[i], msg_data[i]});
  endtask

  task automatic pulse_ped();
    ped = 1'b1;
    step();
    ped = 1'b0;
  endtask

  task automatic wait_tx(input int target, input string name);
    int n = 0;
    while (tx_cnt < target && n < 300) begin step(); n++; end
    chk(name, tx_cnt, target);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 300) begin step(); n++; end
    chk(name, done_cnt, target);
  endtask

  initial begin
    int t0, d0;
    logic [7:0] held;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i);
    for (int i = 0; i < 4; i++) mem[msg_addr[i]] = msg_data[i];

    // Reset state.
    step(); step();
    chk("rst_mem_addr", mem_addr, 8'hFE);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step();

    // Latency with tx_ready held high, 1-cycle transmitter.
    tx_busy = 1;
    push_msg(4);
    pulse_ped();
    chk("lat_busy_n1", busy, 1);
    chk("lat_addr_n1", mem_addr, 8'hFE);
    chk("lat_start_n1", tx_start, 0);
    step(); chk("lat_start_n2", tx_start, 0);
    step(); chk("lat_start_n3", tx_start, 0);
    step(); chk("lat_start_n4", tx_start, 1);
    wait_done(1, "lat_done");
    chk("lat_busy_in_done", busy, 1);
    step();
    chk("lat_busy_after", busy, 0);
    chk("lat_done_width", done, 0);
    chk("lat_tx_count", tx_cnt, 4);

    // Basic transfer with a slow transmitter plus an ignored ped mid-transfer,
    // then ped in the DONE cycle (ignored) and right after it (accepted).
    tx_busy = 10;
    t0 = tx_cnt; d0 = done_cnt;
    push_msg(4);
    pulse_ped();
    wait_tx(t0 + 2, "basic_byte2");
    pulse_ped();
    wait_done(d0 + 1, "basic_done");
    chk("basic_tx_count", tx_cnt, t0 + 4);
    ped = 1'b1;
    step();
    ped = 1'b0;
    chk("ped_in_done_ignored", busy, 0);
    push_msg(4);
    pulse_ped();
    chk("ped_after_done_starts", busy, 1);
    wait_done(d0 + 2, "restart_done");
    step(); step();

    // Abort while waiting for the transmitter before byte 3.
    t0 = tx_cnt; d0 = done_cnt;
    push_msg(2);
    pulse_ped();
    wait_tx(t0 + 2, "abort_pre_bytes");
    stall = 1'b1;
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_tx_start", tx_start, 0);
    chk("abort_addr", mem_addr, 8'hFE);
    stall = 1'b0;
    repeat (30) step();
    chk("abort_no_more_tx", tx_cnt, t0 + 2);
    chk("abort_no_done", done_cnt, d0);

    // abort and ped together in IDLE: stays idle.
    abort = 1'b1;
    pulse_ped();
    abort = 1'b0;
    chk("abort_beats_ped", busy, 0);
    step();
    chk("abort_beats_ped2", busy, 0);

    // Stalled transmitter after a fresh start from START_ADDR.
    t0 = tx_cnt; d0 = done_cnt;
    stall = 1'b1;
    push_msg(4);
    pulse_ped();
    repeat (50) step();
    chk("stall_no_tx", tx_cnt, t0);
    chk("stall_tx_start", tx_start, 0);
    chk("stall_tx_data", tx_data, 8'h41);
    chk("stall_busy", busy, 1);
    stall = 1'b0;
    step();
    chk("stall_release_strobe", tx_start, 1);
    wait_done(d0 + 1, "stall_done");
    step(); step();

    // Reset mid-transfer.
    t0 = tx_cnt; d0 = done_cnt;
    push_msg(2);
    pulse_ped();
    wait_tx(t0 + 2, "rst_mid_bytes");
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_mid_tx_start", tx_start, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_tx_data", tx_data, 8'h00);
    chk("rst_mid_addr", mem_addr, 8'hFE);
    reset = 1'b0;
    repeat (30) step();
    chk("rst_mid_no_tx", tx_cnt, t0 + 2);
    chk("rst_mid_no_done", done_cnt, d0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
